// File: rtl/wdt_svc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : wdt_svc_pkg
// Purpose  : Shared types and default constants for the WDT service controller
//            (transfer FSM states, requester identifiers, WDT register map).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package wdt_svc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      CAPTURE = 2'd3
   } xfer_state_e;

   typedef enum logic [1:0] {
      REQ_INIT = 2'd0,
      REQ_KICK = 2'd1,
      REQ_CPU  = 2'd2
   } req_e;

   localparam int c_ADDR_W       = 8;
   localparam int c_DATA_W       = 21;
   localparam int c_CLK_DIV_ADDR = 'h11;
   localparam int c_KICK_ADDR    = 'h22;
   localparam int c_TIMEOUT_ADDR = 'h33;
   localparam int c_CLK_DIV_INIT = 0;
   localparam int c_TIMEOUT_INIT = 25;
   localparam int c_KICK_VALUE   = 1;
   localparam int c_KICK_PERIOD  = 16;
   localparam int c_TIMER_W      = 16;

endpackage : wdt_svc_pkg
`default_nettype wire

// File: rtl/wdt_kick_timer.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : wdt_kick_timer
// Purpose  : Free-running kick period counter with a single-entry pending flag.
// Ports    : pclk, presetn      - clock, asynchronous active-low reset
//            enable             - count only while the WDT is programmed
//            clear              - synchronous clear of counter and flag
//            consume            - kick transfer has been launched
//            kick_pending       - a kick is owed to the WDT
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module wdt_kick_timer
   import wdt_svc_pkg::*;
#(
   parameter int KICK_PERIOD = c_KICK_PERIOD
) (
   input  logic pclk,
   input  logic presetn,
   input  logic enable,
   input  logic clear,
   input  logic consume,
   output logic kick_pending
);

   localparam logic [c_TIMER_W-1:0] c_LAST = c_TIMER_W'(KICK_PERIOD - 1);

   logic [c_TIMER_W-1:0] r_count;
   logic                 r_pending;
   logic                 w_expire;

   assign w_expire = enable && (r_count == c_LAST);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_count   <= '0;
         r_pending <= 1'b0;
      end else if (clear) begin
         r_count   <= '0;
         r_pending <= 1'b0;
      end else begin
         if (enable) begin
            r_count <= w_expire ? '0 : r_count + 1'b1;
         end
         // A fresh expiry on the consume edge is a new kick and must survive;
         // an expiry while already pending simply merges into it.
         if (w_expire) begin
            r_pending <= 1'b1;
         end else if (consume) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign kick_pending = r_pending;

endmodule : wdt_kick_timer
`default_nettype wire

// File: rtl/wdt_service_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : wdt_service_ctrl
// Purpose  : Programs the WDT after reset, kicks it periodically and shares the
//            single WDT register port with CPU requests (non-preemptive).
// Ports    : pclk/presetn                     - clock, async active-low reset
//            cpu_req/wr/addr/wdata            - CPU request (held until ack)
//            cpu_ack/rdata/err                - CPU completion
//            paddr/pwdata/wren/rden/prdata    - WDT register port
//            cpu_reset_trig                   - WDT timeout pulse
//            init_done/wdt_fired              - status
// Config   : WDT_CPU_KICK_BLOCK_EN - reject CPU writes to the kick register
//            with cpu_err instead of forwarding them.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module wdt_service_ctrl
   import wdt_svc_pkg::*;
#(
   parameter int                ADDR_W       = c_ADDR_W,
   parameter int                DATA_W       = c_DATA_W,
   parameter logic [ADDR_W-1:0] CLK_DIV_ADDR = ADDR_W'(c_CLK_DIV_ADDR),
   parameter logic [ADDR_W-1:0] KICK_ADDR    = ADDR_W'(c_KICK_ADDR),
   parameter logic [ADDR_W-1:0] TIMEOUT_ADDR = ADDR_W'(c_TIMEOUT_ADDR),
   parameter int                CLK_DIV_INIT = c_CLK_DIV_INIT,
   parameter int                TIMEOUT_INIT = c_TIMEOUT_INIT,
   parameter int                KICK_VALUE   = c_KICK_VALUE,
   parameter int                KICK_PERIOD  = c_KICK_PERIOD
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   output logic              wren,
   output logic              rden,
   input  logic [DATA_W-1:0] prdata,
   input  logic              cpu_reset_trig,
   output logic              init_done,
   output logic              wdt_fired
);

   xfer_state_e       r_state, w_state_nxt;
   req_e              r_owner, w_sel_owner;
   logic              r_wr, w_sel_wr;
   logic [ADDR_W-1:0] r_paddr, w_sel_addr;
   logic [DATA_W-1:0] r_pwdata, w_sel_data;
   logic              r_wren, r_rden;
   logic              r_cpu_ack;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic              r_init_done, r_init_step, r_stale, r_fired;
   logic              w_start, w_kick_pending, w_consume;
`ifdef WDT_CPU_KICK_BLOCK_EN
   logic              w_block;
   logic              r_cpu_err;
`endif

   wdt_kick_timer #(
      .KICK_PERIOD (KICK_PERIOD)
   ) u_kick_timer (
      .pclk         (pclk),
      .presetn      (presetn),
      .enable       (r_init_done),
      .clear        (cpu_reset_trig),
      .consume      (w_consume),
      .kick_pending (w_kick_pending)
   );

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state and arbitration. Reads drive pwdata=0 so that a CPU read of
   // the kick register never presents the kick address/data pair.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_sel_owner = REQ_INIT;
      w_sel_wr    = 1'b1;
      w_sel_addr  = '0;
      w_sel_data  = '0;
`ifdef WDT_CPU_KICK_BLOCK_EN
      w_block     = 1'b0;
`endif
      unique case (r_state)
         IDLE: begin
            if (!r_init_done) begin
               w_start     = 1'b1;
               w_sel_owner = REQ_INIT;
               w_sel_addr  = r_init_step ? TIMEOUT_ADDR : CLK_DIV_ADDR;
               w_sel_data  = r_init_step ? DATA_W'(TIMEOUT_INIT) : DATA_W'(CLK_DIV_INIT);
            end else if (w_kick_pending) begin
               w_start     = 1'b1;
               w_sel_owner = REQ_KICK;
               w_sel_addr  = KICK_ADDR;
               w_sel_data  = DATA_W'(KICK_VALUE);
            end else if (cpu_req && !r_cpu_ack) begin
`ifdef WDT_CPU_KICK_BLOCK_EN
               w_block = cpu_wr && (cpu_addr == KICK_ADDR);
`endif
               w_start     = 1'b1;
`ifdef WDT_CPU_KICK_BLOCK_EN
               w_start     = !w_block;
`endif
               w_sel_owner = REQ_CPU;
               w_sel_wr    = cpu_wr;
               w_sel_addr  = cpu_addr;
               w_sel_data  = cpu_wr ? cpu_wdata : '0;
            end
            if (w_start) w_state_nxt = SETUP;
         end
         SETUP:   w_state_nxt = ACCESS;
         ACCESS:  w_state_nxt = CAPTURE;
         CAPTURE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_consume = w_start && (w_sel_owner == REQ_KICK);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_owner     <= REQ_INIT;
         r_wr        <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_wren      <= 1'b0;
         r_rden      <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_cpu_rdata <= '0;
         r_init_done <= 1'b0;
         r_init_step <= 1'b0;
         r_stale     <= 1'b0;
         r_fired     <= 1'b0;
`ifdef WDT_CPU_KICK_BLOCK_EN
         r_cpu_err   <= 1'b0;
`endif
      end else begin
         r_cpu_ack   <= 1'b0;
         r_cpu_rdata <= '0;
         r_wren      <= (r_state == SETUP) &&  r_wr;
         r_rden      <= (r_state == SETUP) && !r_wr;
`ifdef WDT_CPU_KICK_BLOCK_EN
         r_cpu_err   <= 1'b0;
         if (w_block) begin
            r_cpu_ack <= 1'b1;
            r_cpu_err <= 1'b1;
         end
`endif
         if (w_start) begin
            r_owner  <= w_sel_owner;
            r_wr     <= w_sel_wr;
            r_paddr  <= w_sel_addr;
            r_pwdata <= w_sel_data;
            r_stale  <= 1'b0;
         end
         if (r_state == CAPTURE) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            if (r_owner == REQ_CPU) begin
               r_cpu_ack   <= 1'b1;
               r_cpu_rdata <= r_wr ? '0 : prdata;
            end
            // An init write overtaken by a timeout must not advance the
            // sequence; init restarts from the clock-divider write.
            if (r_owner == REQ_INIT && !r_stale) begin
               r_init_step <= !r_init_step;
               if (r_init_step) r_init_done <= 1'b1;
            end
         end
         if (cpu_reset_trig) begin
            r_fired     <= 1'b1;
            r_init_done <= 1'b0;
            r_init_step <= 1'b0;
            r_stale     <= 1'b1;
         end
      end
   end

   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;
   assign wren      = r_wren;
   assign rden      = r_rden;
   assign cpu_ack   = r_cpu_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign init_done = r_init_done;
   assign wdt_fired = r_fired;
`ifdef WDT_CPU_KICK_BLOCK_EN
   assign cpu_err   = r_cpu_err;
`else
   assign cpu_err   = 1'b0;
`endif

endmodule : wdt_service_ctrl
`default_nettype wire
